// File: rtl/stack_exec_seq.sv
`default_nettype none
// ============================================================================
// Module  : stack_exec_seq
// Brief   : Pops operands, drives a combinational ALU, pushes results back.
// Revision: 1.0
// ============================================================================
module stack_exec_seq #(
    parameter int WIDTH    = 32,
    parameter int MAX_POP  = 3,
    parameter int MAX_PUSH = 2,
    parameter int CW       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [1:0]             issue_mode,
    input  logic [CW-1:0]          issue_pops,
    input  logic [CW-1:0]          issue_pushes,
    input  logic [MAX_PUSH*CW-1:0] issue_perm,
    input  logic [3:0]             issue_aluop,
    input  logic [WIDTH-1:0]       issue_const,
    output logic [3:0]             alu_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    input  logic [WIDTH-1:0]       alu_lo,
    input  logic [WIDTH-1:0]       alu_hi,
    output logic                   stack_trigger,
    output logic                   stack_push,
    output logic [WIDTH-1:0]       stack_wdata,
    input  logic [WIDTH-1:0]       stack_rdata,
    input  logic                   stack_done,
    input  logic                   stack_empty,
    input  logic                   stack_full,
    output logic                   busy,
    output logic                   op_done,
    output logic                   op_err
);

    localparam int            c_SLOTS     = 1 << CW;
    localparam logic [1:0]    c_MODE_ALU   = 2'b00;
    localparam logic [1:0]    c_MODE_CONST = 2'b01;
    localparam logic [1:0]    c_MODE_PERM  = 2'b10;
    localparam logic [1:0]    c_MODE_WIDE  = 2'b11;
    localparam logic [CW:0]   c_MAX_POP    = (CW+1)'(MAX_POP);
    localparam logic [CW:0]   c_MAX_PUSH   = (CW+1)'(MAX_PUSH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_POP_REQ   = 3'd1,
        S_POP_WAIT  = 3'd2,
        S_EXEC      = 3'd3,
        S_PUSH_REQ  = 3'd4,
        S_PUSH_WAIT = 3'd5,
        S_DONE      = 3'd6,
        S_ERR       = 3'd7
    } state_t;

    state_t                   r_state;
    logic [1:0]               r_mode;
    logic [CW-1:0]            r_pushes;
    logic [MAX_PUSH*CW-1:0]   r_perm;
    logic [3:0]               r_aluop;
    logic [WIDTH-1:0]         r_const;
    logic [CW-1:0]            r_cnt;
    logic [CW-1:0]            r_idx;
    logic [CW-1:0]            r_n;
    logic [WIDTH-1:0]         r_opnd [c_SLOTS];
    logic [WIDTH-1:0]         r_pbuf [c_SLOTS];
    logic                     r_push;
    logic [WIDTH-1:0]         r_wdata;

    logic                     w_issue_err;
    logic [WIDTH-1:0]         w_pbuf [c_SLOTS];
    logic [CW-1:0]            w_n;
    logic [CW-1:0]            w_idx_nxt;

    assign issue_ready   = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign op_done       = (r_state == S_DONE);
    assign op_err        = (r_state == S_ERR);
    assign stack_trigger = ((r_state == S_POP_REQ)  && !stack_empty) ||
                           ((r_state == S_PUSH_REQ) && !stack_full);
    assign stack_push    = r_push;
    assign stack_wdata   = r_wdata;
    assign alu_op        = r_aluop;
    assign alu_a         = r_opnd[0];
    assign alu_b         = r_opnd[1];
    assign w_idx_nxt     = r_idx + CW'(1);

    // Only permute slots below the push count are range-checked.
    always_comb begin
        w_issue_err = ({1'b0, issue_pops} > c_MAX_POP);
        if (issue_mode == c_MODE_WIDE && MAX_PUSH < 2)
            w_issue_err = 1'b1;
        if (issue_mode == c_MODE_PERM) begin
            if ({1'b0, issue_pushes} > c_MAX_PUSH)
                w_issue_err = 1'b1;
            for (int j = 0; j < MAX_PUSH; j++)
                if (j < int'(issue_pushes) && issue_perm[j*CW +: CW] >= issue_pops)
                    w_issue_err = 1'b1;
        end
    end

    always_comb begin
        for (int j = 0; j < c_SLOTS; j++)
            w_pbuf[j] = r_pbuf[j];
        w_n = '0;
        case (r_mode)
            c_MODE_ALU: begin
                w_pbuf[0] = alu_lo;
                w_n       = CW'(1);
            end
            c_MODE_CONST: begin
                w_pbuf[0] = r_const;
                w_n       = CW'(1);
            end
            c_MODE_WIDE: begin
                w_pbuf[0] = alu_lo;
                w_pbuf[1] = alu_hi;
                w_n       = CW'(2);
            end
            default: begin
                for (int j = 0; j < MAX_PUSH; j++)
                    w_pbuf[j] = r_opnd[r_perm[j*CW +: CW]];
                w_n = r_pushes;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mode   <= '0;
            r_pushes <= '0;
            r_perm   <= '0;
            r_aluop  <= '0;
            r_const  <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_n      <= '0;
            r_push   <= 1'b0;
            r_wdata  <= '0;
            for (int i = 0; i < c_SLOTS; i++) begin
                r_opnd[i] <= '0;
                r_pbuf[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (issue_valid) begin
                        r_mode   <= issue_mode;
                        r_pushes <= issue_pushes;
                        r_perm   <= issue_perm;
                        r_aluop  <= issue_aluop;
                        r_const  <= issue_const;
                        r_cnt    <= issue_pops;
                        if (w_issue_err)
                            r_state <= S_ERR;
                        else if (issue_pops != '0) begin
                            r_state <= S_POP_REQ;
                            r_push  <= 1'b0;
                        end else
                            r_state <= S_EXEC;
                    end
                end
                S_POP_REQ:
                    r_state <= stack_empty ? S_ERR : S_POP_WAIT;
                // The first word popped is the top of stack and lands in the highest slot.
                S_POP_WAIT: begin
                    if (stack_done) begin
                        r_opnd[r_cnt - CW'(1)] <= stack_rdata;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1))
                            r_state <= S_EXEC;
                        else begin
                            r_state <= S_POP_REQ;
                            r_push  <= 1'b0;
                        end
                    end
                end
                S_EXEC: begin
                    for (int j = 0; j < c_SLOTS; j++)
                        r_pbuf[j] <= w_pbuf[j];
                    r_n   <= w_n;
                    r_idx <= '0;
                    if (w_n == '0)
                        r_state <= S_DONE;
                    else begin
                        r_state <= S_PUSH_REQ;
                        r_push  <= 1'b1;
                        r_wdata <= w_pbuf[0];
                    end
                end
                S_PUSH_REQ:
                    r_state <= stack_full ? S_ERR : S_PUSH_WAIT;
                S_PUSH_WAIT: begin
                    if (stack_done) begin
                        r_idx <= w_idx_nxt;
                        if (w_idx_nxt == r_n)
                            r_state <= S_DONE;
                        else begin
                            r_state <= S_PUSH_REQ;
                            r_push  <= 1'b1;
                            r_wdata <= r_pbuf[w_idx_nxt];
                        end
                    end
                end
                default:
                    r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_exec_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_stack_exec_seq
// Brief   : Self-checking bench: stack model, ALU model, push scoreboard.
// Revision: 1.0
// ============================================================================
module tb_stack_exec_seq;

    localparam int WIDTH    = 32;
    localparam int MAX_POP  = 2;
    localparam int MAX_PUSH = 2;
    localparam int CW       = 2;
    localparam int CAP      = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   issue_valid = 1'b0;
    logic                   issue_ready;
    logic [1:0]             issue_mode = '0;
    logic [CW-1:0]          issue_pops = '0;
    logic [CW-1:0]          issue_pushes = '0;
    logic [MAX_PUSH*CW-1:0] issue_perm = '0;
    logic [3:0]             issue_aluop = '0;
    logic [WIDTH-1:0]       issue_const = '0;
    logic [3:0]             alu_op;
    logic [WIDTH-1:0]       alu_a, alu_b, alu_lo, alu_hi;
    logic                   stack_trigger, stack_push;
    logic [WIDTH-1:0]       stack_wdata;
    logic [WIDTH-1:0]       stack_rdata = '0;
    logic                   stack_done = 1'b0;
    logic                   stack_empty = 1'b1;
    logic                   stack_full = 1'b0;
    logic                   busy, op_done, op_err;

    always #5 clk = ~clk;

    stack_exec_seq #(.WIDTH(WIDTH), .MAX_POP(MAX_POP), .MAX_PUSH(MAX_PUSH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_mode(issue_mode),
        .issue_pops(issue_pops), .issue_pushes(issue_pushes), .issue_perm(issue_perm),
        .issue_aluop(issue_aluop), .issue_const(issue_const),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_lo(alu_lo), .alu_hi(alu_hi),
        .stack_trigger(stack_trigger), .stack_push(stack_push), .stack_wdata(stack_wdata),
        .stack_rdata(stack_rdata), .stack_done(stack_done), .stack_empty(stack_empty),
        .stack_full(stack_full), .busy(busy), .op_done(op_done), .op_err(op_err)
    );

    // ALU model: op 0 = add, op 1 = full-width multiply.
    logic [2*WIDTH-1:0] prod;
    assign prod = (2*WIDTH)'(alu_a) * (2*WIDTH)'(alu_b);
    always_comb begin
        alu_lo = '0;
        alu_hi = '0;
        case (alu_op)
            4'd0: alu_lo = alu_a + alu_b;
            4'd1: {alu_hi, alu_lo} = prod;
            default: ;
        endcase
    end

    // Stack model
    logic [WIDTH-1:0] mem [CAP];
    logic [WIDTH-1:0] load_v [CAP];
    logic [WIDTH-1:0] obs [64];
    logic [WIDTH-1:0] t_wdata;
    logic             t_push;
    bit               pend = 1'b0;
    int sp = 0, wcnt = 0, n_trig = 0, cyc = 0, obs_wr = 0;
    int load_n = 0, load_gen = 0, load_seen = 0, done_delay = 0;

    task automatic model_fire();
        pend = 1'b0;
        stack_done <= 1'b1;
        if (t_push) begin
            if (sp < CAP) begin
                mem[sp] = t_wdata;
                sp++;
            end
            if (obs_wr < 64) obs[obs_wr] = t_wdata;
            obs_wr++;
        end else if (sp > 0) begin
            sp--;
            stack_rdata <= mem[sp];
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        stack_done <= 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (load_gen != load_seen) begin
                load_seen = load_gen;
                sp = load_n;
                for (int i = 0; i < CAP; i++) mem[i] = load_v[i];
            end
            if (pend) begin
                if (wcnt != 0) wcnt--;
                if (wcnt == 0) model_fire();
            end
            if (stack_trigger) begin
                n_trig++;
                if (!pend) begin
                    pend = 1'b1;
                    wcnt = done_delay;
                    t_push = stack_push;
                    t_wdata = stack_wdata;
                    if (wcnt == 0) model_fire();
                end
            end
        end
        stack_empty <= (sp == 0);
        stack_full  <= (sp == CAP);
    end

    // Bench state
    int tests_run = 0, tests_failed = 0;
    int obs_rd = 0, acc = 0, r_lat = 0, r_trigs = 0;
    bit r_done = 1'b0, r_err = 1'b0;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] e_w, o_w;

    task automatic load_stack(input int n, input logic [WIDTH-1:0] v0, v1, v2, v3);
        @(negedge clk);
        load_v[0] = v0; load_v[1] = v1; load_v[2] = v2; load_v[3] = v3;
        load_n = n;
        load_gen++;
        @(posedge clk);
    endtask

    task automatic run_op(input logic [1:0] mode, input logic [CW-1:0] pops, pushes,
                          input logic [MAX_PUSH*CW-1:0] perm, input logic [3:0] aop,
                          input logic [WIDTH-1:0] cval);
        bit got;
        int t0;
        @(negedge clk);
        t0 = n_trig;
        issue_mode = mode; issue_pops = pops; issue_pushes = pushes;
        issue_perm = perm; issue_aluop = aop; issue_const = cval;
        issue_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        issue_valid = 1'b0;
        issue_const = $urandom;
        issue_aluop = 4'(aop + 4'd3);
        issue_perm  = ~perm;
        got = 1'b0; r_done = 1'b0; r_err = 1'b0; r_lat = -1;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (op_done || op_err) begin
                got = 1'b1;
                r_done = op_done;
                r_err = op_err;
                r_lat = cyc - acc + 1;
            end
        end
        r_trigs = n_trig - t0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if ({stack_trigger, stack_push, op_done, op_err, busy, issue_ready} !== 6'b000001) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 000001",
                     {stack_trigger, stack_push, op_done, op_err, busy, issue_ready});
        end
        tests_run++;
        if ({stack_wdata, alu_op, alu_a, alu_b} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: wdata %h aluop %h a %h b %h expected 0",
                     stack_wdata, alu_op, alu_a, alu_b);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_add();
        load_stack(2, 32'd5, 32'd7, 0, 0);
        exp_q.push_back(32'd12);
        run_op(2'b00, 2'd2, 2'd0, '0, 4'd0, 32'h0);
        tests_run++;
        if (!r_done || r_lat != 8) begin
            tests_failed++;
            $display("FAIL alu_latency: done %0d lat %0d expected done 1 lat 8", r_done, r_lat);
        end
        tests_run++;
        if (r_trigs != 3) begin
            tests_failed++;
            $display("FAIL alu_triggers: got %0d expected 3", r_trigs);
        end
        tests_run++;
        if (alu_a !== 32'd5 || alu_b !== 32'd7) begin
            tests_failed++;
            $display("FAIL alu_operands: a %0d b %0d expected a 5 b 7", alu_a, alu_b);
        end
        while (exp_q.size() > 0) begin
            e_w = exp_q.pop_front();
            o_w = (obs_rd < obs_wr) ? obs[obs_rd] : 'x;
            obs_rd++;
            tests_run++;
            if (o_w !== e_w) begin
                tests_failed++;
                $display("FAIL alu_push: got %h expected %h", o_w, e_w);
            end
        end
    endtask

    task automatic test_const();
        load_stack(0, 0, 0, 0, 0);
        exp_q.push_back(32'hDEADBEEF);
        run_op(2'b01, 2'd0, 2'd0, '0, 4'd0, 32'hDEADBEEF);
        tests_run++;
        if (!r_done || r_lat != 4 || r_trigs != 1) begin
            tests_failed++;
            $display("FAIL const_op: done %0d lat %0d trig %0d expected 1 4 1", r_done, r_lat, r_trigs);
        end
        while (exp_q.size() > 0) begin
            e_w = exp_q.pop_front();
            o_w = (obs_rd < obs_wr) ? obs[obs_rd] : 'x;
            obs_rd++;
            tests_run++;
            if (o_w !== e_w) begin
                tests_failed++;
                $display("FAIL const_push: got %h expected %h", o_w, e_w);
            end
        end
    endtask

    task automatic test_permute();
        load_stack(2, 32'd5, 32'd7, 0, 0);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd5);
        run_op(2'b10, 2'd2, 2'd2, 4'b0001, 4'd0, 32'h0);
        tests_run++;
        if (!r_done || r_lat != 10 || r_trigs != 4) begin
            tests_failed++;
            $display("FAIL swap_op: done %0d lat %0d trig %0d expected 1 10 4", r_done, r_lat, r_trigs);
        end
        load_stack(1, 32'd9, 0, 0, 0);
        exp_q.push_back(32'd9);
        exp_q.push_back(32'd9);
        run_op(2'b10, 2'd1, 2'd2, 4'b0000, 4'd0, 32'h0);
        tests_run++;
        if (!r_done || r_lat != 8 || r_trigs != 3) begin
            tests_failed++;
            $display("FAIL dup_op: done %0d lat %0d trig %0d expected 1 8 3", r_done, r_lat, r_trigs);
        end
        while (exp_q.size() > 0) begin
            e_w = exp_q.pop_front();
            o_w = (obs_rd < obs_wr) ? obs[obs_rd] : 'x;
            obs_rd++;
            tests_run++;
            if (o_w !== e_w) begin
                tests_failed++;
                $display("FAIL perm_push: got %h expected %h", o_w, e_w);
            end
        end
    endtask

    // 3 * 0xAAAAAAAB = 0x2_00000001, so lo = 1 and hi = 2.
    task automatic test_wide_slow();
        load_stack(2, 32'd3, 32'hAAAAAAAB, 0, 0);
        done_delay = 3;
        exp_q.push_back(32'h00000001);
        exp_q.push_back(32'h00000002);
        run_op(2'b11, 2'd2, 2'd0, '0, 4'd1, 32'h0);
        done_delay = 0;
        tests_run++;
        if (!r_done || r_lat != 22 || r_trigs != 4) begin
            tests_failed++;
            $display("FAIL wide_op: done %0d lat %0d trig %0d expected 1 22 4", r_done, r_lat, r_trigs);
        end
        while (exp_q.size() > 0) begin
            e_w = exp_q.pop_front();
            o_w = (obs_rd < obs_wr) ? obs[obs_rd] : 'x;
            obs_rd++;
            tests_run++;
            if (o_w !== e_w) begin
                tests_failed++;
                $display("FAIL wide_push: got %h expected %h", o_w, e_w);
            end
        end
    endtask

    task automatic test_errors();
        load_stack(1, 32'd5, 0, 0, 0);
        run_op(2'b00, 2'd2, 2'd0, '0, 4'd0, 32'h0);
        tests_run++;
        if (!r_err || r_done || r_trigs != 1 || issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL underflow: err %0d done %0d trig %0d ready %b expected 1 0 1 1",
                     r_err, r_done, r_trigs, issue_ready);
        end
        load_stack(3, 32'd1, 32'd2, 32'd3, 0);
        run_op(2'b00, 2'd3, 2'd0, '0, 4'd0, 32'h0);
        tests_run++;
        if (!r_err || r_trigs != 0) begin
            tests_failed++;
            $display("FAIL too_many_pops: err %0d trig %0d expected 1 0", r_err, r_trigs);
        end
        run_op(2'b10, 2'd1, 2'd2, 4'b0100, 4'd0, 32'h0);
        tests_run++;
        if (!r_err || r_trigs != 0) begin
            tests_failed++;
            $display("FAIL perm_range: err %0d trig %0d expected 1 0", r_err, r_trigs);
        end
        load_stack(4, 32'd1, 32'd2, 32'd3, 32'd4);
        run_op(2'b01, 2'd0, 2'd0, '0, 4'd0, 32'h1234);
        tests_run++;
        if (!r_err || r_trigs != 0 || obs_wr != obs_rd) begin
            tests_failed++;
            $display("FAIL overflow: err %0d trig %0d extra pushes %0d expected 1 0 0",
                     r_err, r_trigs, obs_wr - obs_rd);
        end
    endtask

    task automatic test_reset_midop();
        bit seen;
        load_stack(0, 0, 0, 0, 0);
        done_delay = 6;
        @(negedge clk);
        issue_mode = 2'b01; issue_pops = '0; issue_aluop = 4'd5; issue_const = 32'hCAFE0001;
        issue_valid = 1'b1;
        @(posedge clk);
        #1 issue_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = stack_trigger && stack_push;
        end
        @(negedge clk);
        tests_run++;
        if (!seen || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midop_reach: trigger seen %0d busy %b expected 1 1", seen, busy);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({stack_trigger, stack_push, op_done, op_err, busy, issue_ready} !== 6'b000001 ||
            stack_wdata !== '0 || alu_op !== '0) begin
            tests_failed++;
            $display("FAIL midop_reset: ctrl %b wdata %h aluop %h expected 000001 0 0",
                     {stack_trigger, stack_push, op_done, op_err, busy, issue_ready},
                     stack_wdata, alu_op);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_delay = 0;
        load_stack(0, 0, 0, 0, 0);
        exp_q.push_back(32'h0BADF00D);
        run_op(2'b01, 2'd0, 2'd0, '0, 4'd0, 32'h0BADF00D);
        tests_run++;
        if (!r_done || r_lat != 4) begin
            tests_failed++;
            $display("FAIL post_reset_const: done %0d lat %0d expected 1 4", r_done, r_lat);
        end
        while (exp_q.size() > 0) begin
            e_w = exp_q.pop_front();
            o_w = (obs_rd < obs_wr) ? obs[obs_rd] : 'x;
            obs_rd++;
            tests_run++;
            if (o_w !== e_w) begin
                tests_failed++;
                $display("FAIL post_reset_push: got %h expected %h", o_w, e_w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_add();
        test_const();
        test_permute();
        test_wide_slow();
        test_errors();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/stack_exec_seq.md
Name: stack_exec_seq

Overview:
- Parametrised successor to the single-operation control sequencer in the stack-machine core.
- Accepts one pre-decoded operation per handshake and pops 0..MAX_POP operands from the operand stack through the trigger/done stack interface.
- Drives an external combinational ALU, then pushes 0..MAX_PUSH results back.
- Adds over the previous generation: const, wide (lo+hi) and permute (dup/swap-style) modes, stack underflow/overflow detection, and an issue-side ready/valid handshake.

Parameters:
WIDTH, 32, stack word / operand width
MAX_POP, 3, maximum operands popped per operation (>=2)
MAX_PUSH, 2, maximum words pushed per operation (>=2)
CW, 2, width of pop/push count and permute index fields (must hold MAX_POP)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  operation offered
issue_ready  out  1  high only in IDLE; accept = issue_valid & issue_ready
issue_mode  in  2  00 ALU, 01 CONST, 10 PERMUTE, 11 WIDE
issue_pops  in  CW  operands to pop
issue_pushes  in  CW  push count (PERMUTE only)
issue_perm  in  MAX_PUSH*CW  PERMUTE: slot j = operand index for push j
issue_aluop  in  4  ALU op select
issue_const  in  WIDTH  CONST value
alu_op  out  4  latched issue_aluop
alu_a  out  WIDTH  opnd[0]
alu_b  out  WIDTH  opnd[1]
alu_lo  in  WIDTH  ALU low result (combinational)
alu_hi  in  WIDTH  ALU high result
stack_trigger  out  1  one-cycle request strobe
stack_push  out  1  1 = push, 0 = pop (valid with trigger)
stack_wdata  out  WIDTH  push data
stack_rdata  in  WIDTH  pop data, valid with stack_done
stack_done  in  1  transaction complete pulse
stack_empty  in  1  stack has no elements
stack_full  in  1  stack has no free slot
busy  out  1  state != IDLE
op_done  out  1  one-cycle completion pulse
op_err  out  1  one-cycle abort pulse

Behaviour:
- Reset (async, any state): state IDLE; stack_trigger, stack_push, op_done, op_err, busy = 0; stack_wdata, alu_op, opnd[], pbuf[] = 0; issue_ready = 1.
- On accept, all issue_* fields are latched; later changes are ignored.
- States: IDLE, POP_REQ, POP_WAIT, EXEC, PUSH_REQ, PUSH_WAIT, DONE, ERR.
- IDLE, on accept:
  - Go to ERR if issue_pops > MAX_POP, or WIDE with MAX_PUSH<2, or PERMUTE with pushes > MAX_PUSH or any used perm index >= pops.
  - Otherwise pop counter = pops; go to POP_REQ if pops > 0, else EXEC.
- POP_REQ:
  - stack_empty -> ERR, with no trigger issued.
  - Otherwise stack_trigger = 1, stack_push = 0 for this cycle only; go to POP_WAIT.
- POP_WAIT:
  - Trigger low; wait any number of cycles.
  - On stack_done: opnd[counter-1] <= stack_rdata; decrement counter.
  - Next state: EXEC if counter reaches 0, else POP_REQ.
  - Ordering: top of stack lands in the highest index, so for 2 pops alu_b = first pop and alu_a = second pop.
- EXEC (one cycle): fill pbuf and push count.
  - ALU: pbuf[0] = alu_lo, n = 1.
  - CONST: pbuf[0] = issue_const, n = 1.
  - WIDE: pbuf[0] = alu_lo, pbuf[1] = alu_hi, n = 2.
  - PERMUTE: pbuf[j] = opnd[perm[j]], n = issue_pushes.
  - n = 0 -> DONE, else PUSH_REQ with index 0.
- PUSH_REQ:
  - stack_full -> ERR.
  - Otherwise trigger = 1, stack_push = 1, stack_wdata = pbuf[idx]; go to PUSH_WAIT.
- PUSH_WAIT: on stack_done increment idx; next state DONE if idx = n, else PUSH_REQ.
- stack_wdata and stack_push hold until the next request.
- DONE: op_done = 1 for one cycle, then IDLE.
- ERR: op_err = 1 for one cycle, then IDLE. Already-popped words are not restored; already-pushed words are not retracted.
- stack_done outside POP_WAIT/PUSH_WAIT is ignored. stack_done coincident with the trigger cycle is ignored.
- No stack transaction is ever outstanding when issue_ready is 1.
- Minimum latency, accept to op_done: 2*pops + 2*n + 2 cycles (done returned on the first wait cycle).
- Arithmetic is the ALU's; the sequencer passes words unmodified at full WIDTH.

Test Plan:
- ALU add: stack [5,7], pops=2, aluop=add, bench ALU returns a+b -> pops 7 then 5, alu_a=5, alu_b=7, pushes 12; op_done 8 cycles after accept; exactly 3 trigger pulses.
- CONST, pops=0, const=0xDEADBEEF -> single push of 0xDEADBEEF, no pops, op_done 4 cycles after accept.
- PERMUTE swap (pops=2, pushes=2, perm={1,0}) on [5,7] -> pushes 7 then 5; dup (pops=1, pushes=2, perm={0,0}) on [9] -> pushes 9, 9.
- WIDE mul, bench alu_lo=0x00000001, alu_hi=0x00000002 -> pushes lo then hi; stack_done delayed 3 cycles -> trigger stays low while waiting, order unchanged.
- Underflow: pops=2, stack_empty rises after the first pop -> op_err pulse, no second trigger, issue_ready back high. pops=3 with MAX_POP=2 -> op_err, zero triggers.
- Reset asserted in PUSH_WAIT -> all outputs 0 immediately, issue_ready=1; a following CONST op completes normally.
